// File: rtl/frame_painter.sv
// Draw-command painter for the 112x112 3-bit framebuffer. It writes one pixel per cycle
// and hands each finished frame to the flasher over the continuation handshake.
module frame_painter #(
    parameter int SCR_WIDTH  = 112,
    parameter int SCR_HEIGHT = 112,
    parameter int COORD_BITS = 7,
    parameter int ADDR_SIZE  = 14,
    parameter int COLOR_SIZE = 3
) (
    input  logic                  Clck,
    input  logic                  Reset,
    input  logic                  in_cont_signal,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_op,
    input  logic [COORD_BITS-1:0] cmd_x,
    input  logic [COORD_BITS-1:0] cmd_y,
    input  logic [COORD_BITS-1:0] cmd_w,
    input  logic [COORD_BITS-1:0] cmd_h,
    input  logic [COLOR_SIZE-1:0] cmd_color,
    input  logic                  cmd_last,
    output logic [ADDR_SIZE-1:0]  write_addr,
    output logic [COLOR_SIZE-1:0] write_data,
    output logic                  write_en,
    output logic                  out_cont_signal,
    input  logic                  next_fin_signal,
    output logic                  busy
);

    localparam int SB = COORD_BITS + 1;

    typedef enum logic [1:0] {S_IDLE, S_ACCEPT, S_DRAW, S_HANDOFF} state_t;

    state_t               r_state;
    logic [SB-1:0]        r_x;
    logic [SB-1:0]        r_x_start;
    logic [SB-1:0]        r_x_end;
    logic [SB-1:0]        r_y;
    logic [SB-1:0]        r_y_end;
    logic [ADDR_SIZE-1:0] r_row_base;
    logic                 r_last;

    logic [SB-1:0]        w_x_sum;
    logic [SB-1:0]        w_y_sum;
    logic [SB-1:0]        w_x0;
    logic [SB-1:0]        w_y0;
    logic [SB-1:0]        w_x_end;
    logic [SB-1:0]        w_y_end;
    logic                 w_empty;
    logic [ADDR_SIZE-1:0] w_base;
    logic [SB-1:0]        w_x_next;
    logic [SB-1:0]        w_y_next;
    logic [ADDR_SIZE-1:0] w_row_next;

    // y*SCR_WIDTH as a constant shift-add, only used once per command to seed the row base
    function automatic logic [ADDR_SIZE-1:0] row_base(input logic [SB-1:0] y);
        logic [ADDR_SIZE-1:0] acc;
        acc = '0;
        for (int i = 0; i < ADDR_SIZE; i++) begin
            acc = acc + (SCR_WIDTH[i] ? (ADDR_SIZE'(y) << i) : {ADDR_SIZE{1'b0}});
        end
        return acc;
    endfunction

    // Clipped bounds of the command on the input bus
    always_comb begin
        w_x_sum = {1'b0, cmd_x} + {1'b0, cmd_w};
        w_y_sum = {1'b0, cmd_y} + {1'b0, cmd_h};
        if (cmd_op) begin
            w_x0    = '0;
            w_y0    = '0;
            w_x_end = SB'(SCR_WIDTH);
            w_y_end = SB'(SCR_HEIGHT);
        end else begin
            w_x0    = {1'b0, cmd_x};
            w_y0    = {1'b0, cmd_y};
            w_x_end = (w_x_sum > SB'(SCR_WIDTH))  ? SB'(SCR_WIDTH)  : w_x_sum;
            w_y_end = (w_y_sum > SB'(SCR_HEIGHT)) ? SB'(SCR_HEIGHT) : w_y_sum;
        end
        w_empty    = (w_x_end <= w_x0) || (w_y_end <= w_y0);
        w_base     = row_base(w_y0);
        w_x_next   = r_x + SB'(1);
        w_y_next   = r_y + SB'(1);
        w_row_next = r_row_base + ADDR_SIZE'(SCR_WIDTH);
    end

    // Painter FSM with registered handshake and write-port outputs
    always_ff @(posedge Clck or posedge Reset) begin
        if (Reset) begin
            r_state         <= S_IDLE;
            r_x             <= '0;
            r_x_start       <= '0;
            r_x_end         <= '0;
            r_y             <= '0;
            r_y_end         <= '0;
            r_row_base      <= '0;
            r_last          <= 1'b0;
            cmd_ready       <= 1'b0;
            write_addr      <= '0;
            write_data      <= '0;
            write_en        <= 1'b0;
            out_cont_signal <= 1'b0;
            busy            <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_cont_signal) begin
                        r_state   <= S_ACCEPT;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                S_ACCEPT: begin
                    if (cmd_valid) begin
                        r_last     <= cmd_last;
                        write_data <= cmd_color;
                        if (w_empty) begin
                            if (cmd_last) begin
                                r_state         <= S_HANDOFF;
                                cmd_ready       <= 1'b0;
                                out_cont_signal <= 1'b1;
                            end
                        end else begin
                            r_state    <= S_DRAW;
                            cmd_ready  <= 1'b0;
                            write_en   <= 1'b1;
                            write_addr <= w_base + ADDR_SIZE'(w_x0);
                            r_row_base <= w_base;
                            r_x        <= w_x0;
                            r_x_start  <= w_x0;
                            r_x_end    <= w_x_end;
                            r_y        <= w_y0;
                            r_y_end    <= w_y_end;
                        end
                    end
                end
                S_DRAW: begin
                    if (w_x_next == r_x_end) begin
                        if (w_y_next == r_y_end) begin
                            write_en <= 1'b0;
                            if (r_last) begin
                                r_state         <= S_HANDOFF;
                                out_cont_signal <= 1'b1;
                            end else begin
                                r_state   <= S_ACCEPT;
                                cmd_ready <= 1'b1;
                            end
                        end else begin
                            r_x        <= r_x_start;
                            r_y        <= w_y_next;
                            r_row_base <= w_row_next;
                            write_addr <= w_row_next + ADDR_SIZE'(r_x_start);
                        end
                    end else begin
                        r_x        <= w_x_next;
                        write_addr <= write_addr + ADDR_SIZE'(1);
                    end
                end
                S_HANDOFF: begin
                    if (next_fin_signal) begin
                        r_state         <= S_IDLE;
                        out_cont_signal <= 1'b0;
                        busy            <= 1'b0;
                    end
                end
                default: begin
                    r_state         <= S_IDLE;
                    cmd_ready       <= 1'b0;
                    write_en        <= 1'b0;
                    out_cont_signal <= 1'b0;
                    busy            <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_painter.sv
// Directed bench for frame_painter: reset, rectangle fill, clipping, empty commands,
// full clear with handoff, and reset while drawing.
module tb_frame_painter;

    logic        Clck;
    logic        Reset;
    logic        in_cont_signal;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_op;
    logic [6:0]  cmd_x;
    logic [6:0]  cmd_y;
    logic [6:0]  cmd_w;
    logic [6:0]  cmd_h;
    logic [2:0]  cmd_color;
    logic        cmd_last;
    logic [13:0] write_addr;
    logic [2:0]  write_data;
    logic        write_en;
    logic        out_cont_signal;
    logic        next_fin_signal;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    frame_painter dut (
        .Clck            (Clck),
        .Reset           (Reset),
        .in_cont_signal  (in_cont_signal),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_op          (cmd_op),
        .cmd_x           (cmd_x),
        .cmd_y           (cmd_y),
        .cmd_w           (cmd_w),
        .cmd_h           (cmd_h),
        .cmd_color       (cmd_color),
        .cmd_last        (cmd_last),
        .write_addr      (write_addr),
        .write_data      (write_data),
        .write_en        (write_en),
        .out_cont_signal (out_cont_signal),
        .next_fin_signal (next_fin_signal),
        .busy            (busy)
    );

    initial Clck = 1'b0;
    always #5 Clck = ~Clck;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clck);
        #1;
    endtask

    task automatic set_cmd(input logic op, input logic [6:0] x, input logic [6:0] y,
                           input logic [6:0] w, input logic [6:0] h,
                           input logic [2:0] c, input logic last);
        cmd_op    = op;
        cmd_x     = x;
        cmd_y     = y;
        cmd_w     = w;
        cmd_h     = h;
        cmd_color = c;
        cmd_last  = last;
        cmd_valid = 1'b1;
    endtask

    initial begin
        logic [13:0] rect_addr [6];
        int bad;
        int first_bad;

        rect_addr[0] = 14'd570; rect_addr[1] = 14'd571; rect_addr[2] = 14'd572;
        rect_addr[3] = 14'd682; rect_addr[4] = 14'd683; rect_addr[5] = 14'd684;

        Reset = 1'b0; in_cont_signal = 1'b0; cmd_valid = 1'b0; next_fin_signal = 1'b0;
        cmd_op = 1'b0; cmd_x = '0; cmd_y = '0; cmd_w = '0; cmd_h = '0;
        cmd_color = '0; cmd_last = 1'b0;

        // asynchronous reset mid-cycle
        #2 Reset = 1'b1;
        #1;
        check("rst_we",    write_en, 0);
        check("rst_ready", cmd_ready, 0);
        check("rst_cont",  out_cont_signal, 0);
        check("rst_busy",  busy, 0);
        check("rst_addr",  write_addr, 0);
        check("rst_data",  write_data, 0);
        repeat (2) tick();
        Reset = 1'b0;

        // idle ignores commands until in_cont
        cmd_valid = 1'b1;
        repeat (3) tick();
        check("idle_busy",  busy, 0);
        check("idle_ready", cmd_ready, 0);
        check("idle_we",    write_en, 0);
        cmd_valid = 1'b0;

        // 3x2 rectangle at (10,5), colour 5, next_fin pulsed during draw
        in_cont_signal = 1'b1;
        tick();
        in_cont_signal = 1'b0;
        check("acc_ready", cmd_ready, 1);
        check("acc_busy",  busy, 1);
        set_cmd(1'b0, 7'd10, 7'd5, 7'd3, 7'd2, 3'd5, 1'b0);
        tick();
        cmd_valid = 1'b0;
        next_fin_signal = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i == 1) next_fin_signal = 1'b0;
            check($sformatf("rect_we%0d", i),    write_en, 1);
            check($sformatf("rect_addr%0d", i),  write_addr, rect_addr[i]);
            check($sformatf("rect_data%0d", i),  write_data, 5);
            check($sformatf("rect_ready%0d", i), cmd_ready, 0);
            check($sformatf("rect_cont%0d", i),  out_cont_signal, 0);
            tick();
        end
        check("rect_we_done", write_en, 0);
        check("rect_ready",   cmd_ready, 1);
        check("rect_cont",    out_cont_signal, 0);

        // clipped rectangle at the bottom-right corner
        set_cmd(1'b0, 7'd110, 7'd111, 7'd5, 7'd4, 3'd6, 1'b0);
        tick();
        cmd_valid = 1'b0;
        check("clip_we0",   write_en, 1);
        check("clip_addr0", write_addr, 12542);
        tick();
        check("clip_we1",   write_en, 1);
        check("clip_addr1", write_addr, 12543);
        tick();
        check("clip_we_done", write_en, 0);
        check("clip_ready",   cmd_ready, 1);

        // empty non-last, then back-to-back full clear (last)
        set_cmd(1'b0, 7'd3, 7'd3, 7'd0, 7'd4, 3'd1, 1'b0);
        tick();
        check("empty_ready", cmd_ready, 1);
        check("empty_we",    write_en, 0);
        set_cmd(1'b1, 7'd50, 7'd50, 7'd0, 7'd0, 3'b010, 1'b1);
        tick();
        cmd_valid = 1'b0;
        bad = 0;
        first_bad = -1;
        for (int i = 0; i < 12544; i++) begin
            if (!(write_en === 1'b1 && write_addr === 14'(i) && write_data === 3'b010
                  && out_cont_signal === 1'b0)) begin
                if (bad == 0) first_bad = i;
                bad++;
            end
            tick();
        end
        check("clear_bad_pixels", bad, 0);
        check("clear_first_bad",  first_bad, -1);
        check("clr_cont",  out_cont_signal, 1);
        check("clr_we",    write_en, 0);
        check("clr_ready", cmd_ready, 0);
        check("clr_busy",  busy, 1);
        tick();
        check("clr_cont_hold", out_cont_signal, 1);
        next_fin_signal = 1'b1;
        tick();
        next_fin_signal = 1'b0;
        check("fin_cont",  out_cont_signal, 0);
        check("fin_busy",  busy, 0);
        check("fin_ready", cmd_ready, 0);

        // empty last command hands off the next cycle
        in_cont_signal = 1'b1;
        tick();
        in_cont_signal = 1'b0;
        set_cmd(1'b0, 7'd4, 7'd4, 7'd0, 7'd3, 3'd7, 1'b1);
        tick();
        cmd_valid = 1'b0;
        check("el_cont",  out_cont_signal, 1);
        check("el_we",    write_en, 0);
        check("el_ready", cmd_ready, 0);
        next_fin_signal = 1'b1;
        tick();
        next_fin_signal = 1'b0;
        check("el_idle_busy", busy, 0);
        check("el_idle_cont", out_cont_signal, 0);

        // reset while drawing a 20x20 rectangle
        in_cont_signal = 1'b1;
        tick();
        in_cont_signal = 1'b0;
        set_cmd(1'b0, 7'd0, 7'd0, 7'd20, 7'd20, 3'd4, 1'b1);
        tick();
        cmd_valid = 1'b0;
        repeat (5) tick();
        check("rd_we_before",   write_en, 1);
        check("rd_addr_before", write_addr, 5);
        #2 Reset = 1'b1;
        #1;
        check("rd_we",    write_en, 0);
        check("rd_busy",  busy, 0);
        check("rd_addr",  write_addr, 0);
        check("rd_data",  write_data, 0);
        check("rd_ready", cmd_ready, 0);
        #1 Reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 450; i++) begin
            tick();
            if (write_en !== 1'b0 || out_cont_signal !== 1'b0 || busy !== 1'b0) bad++;
        end
        check("rd_quiet", bad, 0);

        // clean restart: single pixel at (1,1), last
        in_cont_signal = 1'b1;
        tick();
        in_cont_signal = 1'b0;
        check("rs_ready", cmd_ready, 1);
        set_cmd(1'b0, 7'd1, 7'd1, 7'd1, 7'd1, 3'd3, 1'b1);
        tick();
        cmd_valid = 1'b0;
        check("rs_we",   write_en, 1);
        check("rs_addr", write_addr, 113);
        check("rs_data", write_data, 3);
        tick();
        check("rs_we_done", write_en, 0);
        check("rs_cont",    out_cont_signal, 1);
        next_fin_signal = 1'b1;
        tick();
        next_fin_signal = 1'b0;
        check("rs_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
